shift_mul_ctrl: RTL and testbench

- Sequencing controller that performs an unsigned 4x4 multiply by time-multiplexing the existing combinational 4-bit left shifter.
- The shifter instance sits outside this block.
- Per multiplier bit k, the controller drives the shifter with operand A and shift amount k, then conditionally accumulates the 7-bit shifted value into an 8-bit product.
- Used wherever a multiply is needed without a dedicated array multiplier.

---
 rtl/shift_mul_ctrl.sv | 58 +++++
 tb/tb_shift_mul_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/shift_mul_ctrl.sv
// shift_mul_ctrl: 4x4 unsigned multiply by sequencing an external 4-bit left shifter
module shift_mul_ctrl #(
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] product,
  output logic [3:0] sh_I,
  output logic [1:0] sh_S,
  input  logic [6:0] sh_Out
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t     state_q;
  logic [3:0] a_q, b_q, b_hi;
  logic [7:0] acc_q, acc_d, product_q;
  logic [1:0] k_q;
  logic       last;
  assign busy    = state_q == CALC;
  assign done    = state_q == DONE;
  assign product = product_q;
  assign sh_I    = busy ? a_q : 4'd0;
  assign sh_S    = busy ? k_q : 2'd0;
  assign acc_d   = acc_q + (b_q[k_q] ? {1'b0, sh_Out} : 8'd0);
  assign b_hi    = b_q >> k_q;
  // early exit once no multiplier bit above k remains set
  assign last    = k_q == 2'd3 || (EARLY_EXIT && b_hi[3:1] == 3'd0);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      k_q       <= '0;
      product_q <= '0;
    end else if (state_q == CALC) begin
      acc_q <= acc_d;
      if (last) begin
        state_q   <= DONE;
        product_q <= acc_d;
      end else begin
        k_q <= k_q + 2'd1;
      end
    end else if (start) begin
      state_q <= CALC;
      a_q     <= a;
      b_q     <= b;
      acc_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= IDLE;
    end
  end
endmodule

// File: tb/tb_shift_mul_ctrl.sv
// tb_shift_mul_ctrl: checks fixed-latency and early-exit controllers against a*b and a latency model
module tb_shift_mul_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] start = 2'b00;
  logic [3:0] a = 4'd0, b = 4'd0;
  logic [1:0] busy, done;
  logic [7:0] product [2];
  logic [3:0] sh_i [2];
  logic [1:0] sh_s [2];
  logic [6:0] sh_out [2];
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  assign sh_out[0] = 7'(sh_i[0]) << sh_s[0];
  assign sh_out[1] = 7'(sh_i[1]) << sh_s[1];

  shift_mul_ctrl #(.EARLY_EXIT(1'b0)) u_fix (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .a(a), .b(b),
    .busy(busy[0]), .done(done[0]), .product(product[0]),
    .sh_I(sh_i[0]), .sh_S(sh_s[0]), .sh_Out(sh_out[0]));

  shift_mul_ctrl #(.EARLY_EXIT(1'b1)) u_ee (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .a(a), .b(b),
    .busy(busy[1]), .done(done[1]), .product(product[1]),
    .sh_I(sh_i[1]), .sh_S(sh_s[1]), .sh_Out(sh_out[1]));

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input int i, input int bv);
    if (i == 0) return 5;
    if (bv == 0) return 2;
    return 2 + $clog2(bv + 1) - 1;
  endfunction

  // one operation on instance i; inputs are scrambled after acceptance
  task automatic op(input int i, input logic [3:0] av, input logic [3:0] bv);
    int cyc;
    logic [7:0] prev;
    prev = product[i];
    @(negedge clk);
    a = av; b = bv; start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
    a = 4'($urandom); b = 4'($urandom);
    chk("held_product", int'(product[i]), int'(prev));
    cyc = 1;
    while (done[i] !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency", cyc, exp_lat(i, int'(bv)));
    chk("product", int'(product[i]), int'(av) * int'(bv));
    @(negedge clk);
    chk("done_pulse", int'(done[i]), 0);
    chk("idle_sh", int'({busy[i], sh_i[i], sh_s[i]}), 0);
  endtask

  initial begin
    int cyc;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", int'(busy[i]), 0);
      chk("rst_done", int'(done[i]), 0);
      chk("rst_product", int'(product[i]), 0);
      chk("rst_sh", int'({sh_i[i], sh_s[i]}), 0);
    end
    rst_n = 1'b1;

    // 13x11: shift amount steps, stray start during CALC is ignored
    @(negedge clk);
    a = 4'd13; b = 4'd11; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("calc_busy", int'(busy[0]), 1);
      chk("calc_sh_S", int'(sh_s[0]), k);
      chk("calc_sh_I", int'(sh_i[0]), 13);
      chk("calc_done", int'(done[0]), 0);
      if (k == 1) begin a = 4'd1; b = 4'd1; start[0] = 1'b1; end
      else start[0] = 1'b0;
      @(negedge clk);
    end
    chk("d13x11_done", int'(done[0]), 1);
    chk("d13x11_product", int'(product[0]), 143);

    // back-to-back: start held in DONE
    a = 4'd4; b = 4'd5; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    chk("b2b_busy", int'(busy[0]), 1);
    chk("b2b_held", int'(product[0]), 143);
    cyc = 1;
    while (done[0] !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("b2b_latency", cyc, 5);
    chk("b2b_product", int'(product[0]), 20);
    @(negedge clk);

    // reset during the second CALC cycle
    a = 4'd13; b = 4'd11; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_busy", int'(busy[0]), 0);
    chk("mid_rst_product", int'(product[0]), 0);
    chk("mid_rst_sh_S", int'(sh_s[0]), 0);
    for (int k = 0; k < 6; k++) begin
      chk("mid_rst_no_done", int'(done[0]), 0);
      @(negedge clk);
    end
    op(0, 4'd3, 4'd5);

    op(0, 4'd15, 4'd15);
    op(0, 4'd0, 4'd9);
    op(0, 4'd7, 4'd0);
    op(1, 4'd6, 4'd1);
    op(1, 4'd6, 4'd4);
    op(1, 4'd6, 4'd8);
    op(1, 4'd7, 4'd0);
    op(1, 4'd9, 4'd4);

    for (int i = 0; i < 2; i++)
      for (int v = 0; v < 256; v++)
        op(i, 4'(v >> 4), 4'(v));

    repeat (40) op(int'($urandom_range(1, 0)), 4'($urandom), 4'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
